cpu7_exu_memctl: RTL and testbench

- Data-memory request controller between the EXU's execute-stage load/store issue and the external data_* bus.
- Registers each accepted memory op and holds data_req with stable fields until data_addr_ok.
- Tracks up to DEPTH outstanding ops in an in-order queue and returns load data with destination register info for writeback.
- Raises a stall request on queue-full or a RAW hazard against an in-flight load.

---
 rtl/cpu7_exu_memctl_if.sv | 21 ++
 rtl/cpu7_exu_memctl.sv | 172 +++++++++++++++++
 tb/tb_cpu7_exu_memctl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu7_exu_memctl_if.sv
// Data-memory bus between the EXU memory controller (master) and the data port (slave).
interface cpu7_exu_memctl_if #(parameter int DW = 32) ();
  logic          data_req;
  logic [DW-1:0] data_addr;
  logic          data_wr;
  logic [3:0]    data_wstrb;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok;
  logic          data_data_ok;
  logic [DW-1:0] data_rdata;

  modport master (
    output data_req, data_addr, data_wr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_addr, data_wr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/cpu7_exu_memctl.sv
// EXU data-memory request controller: holding register, in-order outstanding queue, load writeback
// and RAW stall. Define CPU7_MEMCTL_PERF_EN to add request/stall performance counters.
module cpu7_exu_memctl #(
  parameter int DEPTH = 2,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ecl_mem_valid_e,
  input  logic          ecl_mem_wr_e,
  input  logic [DW-1:0] ecl_mem_addr_e,
  input  logic [3:0]    ecl_mem_wstrb_e,
  input  logic [DW-1:0] ecl_mem_wdata_e,
  input  logic [4:0]    ecl_mem_rd_e,
  input  logic          ecl_mem_wen_e,
  output logic          ctl_ecl_accept_e,
  input  logic [4:0]    ecl_rs1_d,
  input  logic [4:0]    ecl_rs2_d,
  output logic          ctl_ifu_stall_req,
  cpu7_exu_memctl_if.master bus,
  output logic [DW-1:0] ctl_rdata_m,
  output logic          ctl_rdata_valid_m,
  output logic [4:0]    ctl_rd_m,
  output logic          ctl_wen_m,
  output logic          ctl_idle,
  output logic          ctl_err
`ifdef CPU7_MEMCTL_PERF_EN
  ,
  output logic [31:0]   ctl_perf_req_cnt,
  output logic [31:0]   ctl_perf_stall_cnt
`endif
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 2;

  logic          r_hr_vld, r_hr_wr, r_hr_wen;
  logic [DW-1:0] r_hr_addr, r_hr_wdata;
  logic [3:0]    r_hr_wstrb;
  logic [4:0]    r_hr_rd;

  logic          r_q_wr  [DEPTH];
  logic          r_q_wen [DEPTH];
  logic [4:0]    r_q_rd  [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_cnt;

  logic [DW-1:0] r_rdata_m;
  logic          r_rdata_valid, r_wen_m, r_err;
  logic [4:0]    r_rd_m;

  logic          w_push, w_pop, w_accept, w_hit, w_stall;
  logic          w_head_wr, w_head_wen;
  logic [4:0]    w_head_rd;
  logic [CW-1:0] w_cnt_after_pop;

  function automatic logic rs_hit(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

  assign w_push          = r_hr_vld & bus.data_addr_ok;
  assign w_pop           = bus.data_data_ok & (r_cnt != '0);
  // Outstanding count includes the holding register; a data_ok pop frees a slot this cycle.
  assign w_cnt_after_pop = CW'(r_hr_vld) + r_cnt - CW'(w_pop);
  assign w_accept        = ecl_mem_valid_e & (~r_hr_vld | bus.data_addr_ok)
                         & (w_cnt_after_pop < CW'(DEPTH));

  assign w_head_wr  = r_q_wr[r_rd_ptr];
  assign w_head_wen = r_q_wen[r_rd_ptr];
  assign w_head_rd  = r_q_rd[r_rd_ptr];

  always_comb begin
    logic [PW-1:0] off;
    off   = '0;
    w_hit = r_hr_vld & ~r_hr_wr & r_hr_wen & rs_hit(r_hr_rd, ecl_rs1_d, ecl_rs2_d);
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - r_rd_ptr;
      if ((CW'(off) < r_cnt) && !r_q_wr[i] && r_q_wen[i] && rs_hit(r_q_rd[i], ecl_rs1_d, ecl_rs2_d))
        w_hit = 1'b1;
    end
    // A load stays visible as a hazard through its writeback cycle.
    if (r_rdata_valid & r_wen_m & rs_hit(r_rd_m, ecl_rs1_d, ecl_rs2_d))
      w_hit = 1'b1;
  end

  assign w_stall = (ecl_mem_valid_e & ~w_accept) | w_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hr_vld      <= 1'b0;
      r_hr_wr       <= 1'b0;
      r_hr_wen      <= 1'b0;
      r_hr_addr     <= '0;
      r_hr_wdata    <= '0;
      r_hr_wstrb    <= '0;
      r_hr_rd       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_wr[i]  <= 1'b0;
        r_q_wen[i] <= 1'b0;
        r_q_rd[i]  <= '0;
      end
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_cnt         <= '0;
      r_rdata_m     <= '0;
      r_rdata_valid <= 1'b0;
      r_wen_m       <= 1'b0;
      r_rd_m        <= '0;
      r_err         <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hr_vld   <= 1'b1;
        r_hr_wr    <= ecl_mem_wr_e;
        r_hr_wen   <= ecl_mem_wen_e;
        r_hr_addr  <= ecl_mem_addr_e;
        r_hr_wdata <= ecl_mem_wdata_e;
        r_hr_wstrb <= ecl_mem_wstrb_e;
        r_hr_rd    <= ecl_mem_rd_e;
      end else if (w_push) begin
        r_hr_vld <= 1'b0;
      end
      if (w_push) begin
        r_q_wr[r_wr_ptr]  <= r_hr_wr;
        r_q_wen[r_wr_ptr] <= r_hr_wen;
        r_q_rd[r_wr_ptr]  <= r_hr_rd;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      r_cnt         <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_rdata_valid <= w_pop & ~w_head_wr;
      r_wen_m       <= w_pop & ~w_head_wr & w_head_wen & (w_head_rd != 5'd0);
      if (w_pop & ~w_head_wr) begin
        r_rdata_m <= bus.data_rdata;
        r_rd_m    <= w_head_rd;
      end
      if (bus.data_data_ok && (r_cnt == '0))
        r_err <= 1'b1;
    end
  end

`ifdef CPU7_MEMCTL_PERF_EN
  logic [31:0] r_perf_req, r_perf_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_req   <= '0;
      r_perf_stall <= '0;
    end else begin
      r_perf_req   <= r_perf_req + 32'(w_push);
      r_perf_stall <= r_perf_stall + 32'(w_stall);
    end
  end

  assign ctl_perf_req_cnt   = r_perf_req;
  assign ctl_perf_stall_cnt = r_perf_stall;
`endif

  assign bus.data_req   = r_hr_vld;
  assign bus.data_addr  = r_hr_addr;
  assign bus.data_wr    = r_hr_wr;
  assign bus.data_wstrb = r_hr_wstrb;
  assign bus.data_wdata = r_hr_wdata;

  assign ctl_ecl_accept_e  = w_accept;
  assign ctl_ifu_stall_req = w_stall;
  assign ctl_rdata_m       = r_rdata_m;
  assign ctl_rdata_valid_m = r_rdata_valid;
  assign ctl_rd_m          = r_rd_m;
  assign ctl_wen_m         = r_wen_m;
  assign ctl_err           = r_err;
  assign ctl_idle          = ~r_hr_vld & (r_cnt == '0) & ~r_rdata_valid;
endmodule

// File: tb/tb_cpu7_exu_memctl.sv
// Directed bench for cpu7_exu_memctl (DEPTH=2): vector table plus hand sequences for multi-cycle cases.
module tb_cpu7_exu_memctl;
  logic        clk = 1'b0;
  logic        reset;
  logic        valid, wr, wen;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic [4:0]  rd, rs1, rs2;
  logic        accept, stall, rvalid, wen_m, idle, err;
  logic [31:0] rdata_m;
  logic [4:0]  rd_m;
`ifdef CPU7_MEMCTL_PERF_EN
  logic [31:0] perf_req, perf_stall;
`endif

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu7_exu_memctl_if #(.DW(32)) bus_if ();

  cpu7_exu_memctl #(.DEPTH(2), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .ecl_mem_valid_e(valid), .ecl_mem_wr_e(wr), .ecl_mem_addr_e(addr),
    .ecl_mem_wstrb_e(wstrb), .ecl_mem_wdata_e(wdata), .ecl_mem_rd_e(rd),
    .ecl_mem_wen_e(wen), .ctl_ecl_accept_e(accept),
    .ecl_rs1_d(rs1), .ecl_rs2_d(rs2), .ctl_ifu_stall_req(stall),
    .bus(bus_if),
    .ctl_rdata_m(rdata_m), .ctl_rdata_valid_m(rvalid), .ctl_rd_m(rd_m),
    .ctl_wen_m(wen_m), .ctl_idle(idle), .ctl_err(err)
`ifdef CPU7_MEMCTL_PERF_EN
    , .ctl_perf_req_cnt(perf_req), .ctl_perf_stall_cnt(perf_stall)
`endif
  );

  typedef struct {
    logic v; logic wr; logic [31:0] addr; logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
    logic aok; logic dok; logic [31:0] rdata;
    logic e_acc; logic e_stall; logic e_req; logic [31:0] e_addr;
    logic e_rv; logic [31:0] e_rdata; logic [4:0] e_rd; logic e_wen; logic e_idle;
  } vec_t;

  vec_t vt [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge and settle before checking.
  task automatic cyc(input logic v, input logic w, input logic [31:0] a, input logic [4:0] r,
                     input logic [4:0] s1, input logic [4:0] s2,
                     input logic aok, input logic dok, input logic [31:0] rdat);
    @(negedge clk);
    valid = v; wr = w; addr = a; rd = r; rs1 = s1; rs2 = s2;
    bus_if.data_addr_ok = aok; bus_if.data_data_ok = dok; bus_if.data_rdata = rdat;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    valid = 1'b0; wr = 1'b0; addr = '0; rd = '0; rs1 = '0; rs2 = '0;
    bus_if.data_addr_ok = 1'b0; bus_if.data_data_ok = 1'b0; bus_if.data_rdata = '0;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    wen = 1'b1; wstrb = 4'hF; wdata = 32'h0;
    //          v wr addr         rd rs1 rs2 aok dok rdata           acc stl req e_addr      rv e_rdata        rd wen idle
    vt[0]  = '{1, 0, 32'h1000,    5, 0, 0,   0,  0,  32'h0,          1,  0,  0,  32'h0,      0, 32'h0,         0, 0,  1};
    vt[1]  = '{0, 0, 32'h0,       0, 0, 0,   1,  0,  32'h0,          0,  0,  1,  32'h1000,   0, 32'h0,         0, 0,  0};
    vt[2]  = '{0, 0, 32'h0,       0, 0, 0,   0,  1,  32'hDEADBEEF,   0,  0,  0,  32'h0,      0, 32'h0,         0, 0,  0};
    vt[3]  = '{0, 0, 32'h0,       0, 0, 0,   0,  0,  32'h0,          0,  0,  0,  32'h0,      1, 32'hDEADBEEF,  5, 1,  0};
    vt[4]  = '{0, 0, 32'h0,       0, 0, 0,   0,  0,  32'h0,          0,  0,  0,  32'h0,      0, 32'h0,         0, 0,  1};
    vt[5]  = '{1, 0, 32'h2000,    7, 0, 7,   0,  0,  32'h0,          1,  0,  0,  32'h0,      0, 32'h0,         0, 0,  1};
    vt[6]  = '{0, 0, 32'h0,       0, 0, 7,   0,  0,  32'h0,          0,  1,  1,  32'h2000,   0, 32'h0,         0, 0,  0};
    vt[7]  = '{0, 0, 32'h0,       0, 7, 0,   1,  0,  32'h0,          0,  1,  1,  32'h2000,   0, 32'h0,         0, 0,  0};
    vt[8]  = '{0, 0, 32'h0,       0, 0, 7,   0,  0,  32'h0,          0,  1,  0,  32'h0,      0, 32'h0,         0, 0,  0};
    vt[9]  = '{0, 0, 32'h0,       0, 0, 7,   0,  1,  32'h55,         0,  1,  0,  32'h0,      0, 32'h0,         0, 0,  0};
    vt[10] = '{0, 0, 32'h0,       0, 0, 7,   0,  0,  32'h0,          0,  1,  0,  32'h0,      1, 32'h55,        7, 1,  0};
    vt[11] = '{0, 0, 32'h0,       0, 0, 7,   0,  0,  32'h0,          0,  0,  0,  32'h0,      0, 32'h0,         0, 0,  1};
    vt[12] = '{1, 0, 32'h3000,    0, 0, 0,   0,  0,  32'h0,          1,  0,  0,  32'h0,      0, 32'h0,         0, 0,  1};
    vt[13] = '{0, 0, 32'h0,       0, 0, 0,   1,  0,  32'h0,          0,  0,  1,  32'h3000,   0, 32'h0,         0, 0,  0};
    vt[14] = '{0, 0, 32'h0,       0, 0, 0,   0,  1,  32'hAAAA,       0,  0,  0,  32'h0,      0, 32'h0,         0, 0,  0};
    vt[15] = '{0, 0, 32'h0,       0, 0, 0,   0,  0,  32'h0,          0,  0,  0,  32'h0,      1, 32'hAAAA,      0, 0,  0};
    vt[16] = '{0, 0, 32'h0,       0, 0, 0,   0,  0,  32'h0,          0,  0,  0,  32'h0,      0, 32'h0,         0, 0,  1};

    do_reset();
    chk("rst req",    32'(bus_if.data_req), 32'h0);
    chk("rst idle",   32'(idle), 32'h1);
    chk("rst err",    32'(err), 32'h0);
    chk("rst rvalid", 32'(rvalid), 32'h0);
    chk("rst rdata",  rdata_m, 32'h0);

    for (int i = 0; i < 17; i++) begin
      cyc(vt[i].v, vt[i].wr, vt[i].addr, vt[i].rd, vt[i].rs1, vt[i].rs2,
          vt[i].aok, vt[i].dok, vt[i].rdata);
      chk($sformatf("v%0d accept", i), 32'(accept), 32'(vt[i].e_acc));
      chk($sformatf("v%0d stall", i),  32'(stall),  32'(vt[i].e_stall));
      chk($sformatf("v%0d req", i),    32'(bus_if.data_req), 32'(vt[i].e_req));
      chk($sformatf("v%0d rvalid", i), 32'(rvalid), 32'(vt[i].e_rv));
      chk($sformatf("v%0d idle", i),   32'(idle),   32'(vt[i].e_idle));
      if (vt[i].e_req)
        chk($sformatf("v%0d addr", i), bus_if.data_addr, vt[i].e_addr);
      if (vt[i].e_rv) begin
        chk($sformatf("v%0d rdata", i), rdata_m, vt[i].e_rdata);
        chk($sformatf("v%0d rd", i),    32'(rd_m), 32'(vt[i].e_rd));
        chk($sformatf("v%0d wen", i),   32'(wen_m), 32'(vt[i].e_wen));
      end
    end

    // Address-phase backpressure: fields hold, second op waits.
    cyc(1, 0, 32'h1000, 9, 0, 0, 0, 0, 0);
    chk("bp acc0", 32'(accept), 32'h1);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 32'h1004, 10, 0, 0, 0, 0, 0);
      chk($sformatf("bp%0d req", k),   32'(bus_if.data_req), 32'h1);
      chk($sformatf("bp%0d addr", k),  bus_if.data_addr, 32'h1000);
      chk($sformatf("bp%0d acc", k),   32'(accept), 32'h0);
      chk($sformatf("bp%0d stall", k), 32'(stall), 32'h1);
    end
    cyc(1, 0, 32'h1004, 10, 0, 0, 1, 0, 0);
    chk("bp refill acc", 32'(accept), 32'h1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("bp 2nd addr", bus_if.data_addr, 32'h1004);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h99);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h98);
    chk("bp wb1 rdata", rdata_m, 32'h99);
    chk("bp wb1 rd", 32'(rd_m), 32'd9);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("bp wb2 rdata", rdata_m, 32'h98);
    chk("bp wb2 rd", 32'(rd_m), 32'd10);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("bp idle", 32'(idle), 32'h1);

    // Queue full at DEPTH=2; a same-cycle data_ok frees the slot.
    cyc(1, 0, 32'h4000, 11, 0, 0, 0, 0, 0);
    chk("qf acc1", 32'(accept), 32'h1);
    cyc(1, 0, 32'h4004, 12, 0, 0, 1, 0, 0);
    chk("qf acc2", 32'(accept), 32'h1);
    cyc(1, 0, 32'h4008, 13, 0, 0, 1, 0, 0);
    chk("qf acc3 blocked", 32'(accept), 32'h0);
    chk("qf stall", 32'(stall), 32'h1);
    cyc(1, 0, 32'h4008, 13, 0, 0, 0, 0, 0);
    chk("qf full acc", 32'(accept), 32'h0);
    chk("qf full stall", 32'(stall), 32'h1);
    chk("qf full req", 32'(bus_if.data_req), 32'h0);
    cyc(1, 0, 32'h4008, 13, 0, 0, 0, 1, 32'h111);
    chk("qf pop acc", 32'(accept), 32'h1);
    chk("qf pop stall", 32'(stall), 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 32'h222);
    chk("qf wb1", rdata_m, 32'h111);
    chk("qf wb1 rd", 32'(rd_m), 32'd11);
    chk("qf addr3", bus_if.data_addr, 32'h4008);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h333);
    chk("qf wb2", rdata_m, 32'h222);
    chk("qf wb2 rd", 32'(rd_m), 32'd12);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("qf wb3", rdata_m, 32'h333);
    chk("qf wb3 rd", 32'(rd_m), 32'd13);
    chk("qf wb3 valid", 32'(rvalid), 32'h1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("qf idle", 32'(idle), 32'h1);

    // Store: bus fields, no writeback; then a spurious data_ok sets the sticky error.
    wstrb = 4'b0011; wdata = 32'h12345678;
    cyc(1, 1, 32'h5000, 0, 0, 0, 0, 0, 0);
    chk("st acc", 32'(accept), 32'h1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("st addr", bus_if.data_addr, 32'h5000);
    chk("st wr", 32'(bus_if.data_wr), 32'h1);
    chk("st wstrb", 32'(bus_if.data_wstrb), 32'h3);
    chk("st wdata", bus_if.data_wdata, 32'h12345678);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("st no wb", 32'(rvalid), 32'h0);
    chk("st idle", 32'(idle), 32'h1);
    chk("st err0", 32'(err), 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("err set", 32'(err), 32'h1);
    chk("err no wb", 32'(rvalid), 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("err sticky", 32'(err), 32'h1);
    wstrb = 4'hF; wdata = 32'h0;

    // Reset with the holding register full and one op queued.
    cyc(1, 0, 32'h6000, 14, 0, 0, 0, 0, 0);
    chk("ro acc1", 32'(accept), 32'h1);
    cyc(1, 0, 32'h6004, 15, 0, 0, 1, 0, 0);
    chk("ro acc2", 32'(accept), 32'h1);
    do_reset();
    cyc(0, 0, 0, 0, 15, 14, 0, 0, 0);
    chk("ro req", 32'(bus_if.data_req), 32'h0);
    chk("ro idle", 32'(idle), 32'h1);
    chk("ro err", 32'(err), 32'h0);
    chk("ro no hazard", 32'(stall), 32'h0);
`ifdef CPU7_MEMCTL_PERF_EN
    chk("ro perf req", perf_req, 32'h0);
    chk("ro perf stall", perf_stall, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
